// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding and the default memory depth.
package imem_loader_pkg;

    localparam int DEPTH_DEFAULT = 1024;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        CHK     = 4'd6,
        DONE    = 4'd7,
        ERR     = 4'd8
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, writes it
// into instruction memory one word at a time and holds the CPU until it is verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [15:0]       len;
    logic [15:0]       word;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [7:0]        chk;
    logic [16:0]       len_full;
    logic              accept;
    logic              can_start;
    logic              last_word;

    assign accept    = byte_valid && byte_ready;
    assign can_start = (state == IDLE) || (state == DONE) || (state == ERR);
    assign len_full  = {1'b0, len[15:8], byte_data};
    assign addr_inc  = addr + ADDR_W'(1);
    assign last_word = (addr_inc == ADDR_W'(len));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE, ERR: if (start) state_next = LEN_HI;
            LEN_HI:          if (accept) state_next = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (len_full > DEPTH_L)    state_next = ERR;
                    else if (len_full == '0)   state_next = CHK;
                    else                       state_next = DATA_HI;
                end
            end
            DATA_HI:         if (accept) state_next = DATA_LO;
            DATA_LO:         if (accept) state_next = WRITE;
            WRITE:           state_next = last_word ? CHK : DATA_HI;
            CHK:             if (accept) state_next = (byte_data == chk) ? DONE : ERR;
            default:         state_next = IDLE;
        endcase
    end

    // Datapath: length, word assembly, running checksum and write address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len  <= '0;
            word <= '0;
            addr <= '0;
            chk  <= '0;
        end else begin
            if (can_start && start) begin
                addr <= '0;
                chk  <= '0;
            end
            if (accept && state != CHK) chk <= chk ^ byte_data;
            if (accept && state == LEN_HI)  len[15:8]  <= byte_data;
            if (accept && state == LEN_LO)  len[7:0]   <= byte_data;
            if (accept && state == DATA_HI) word[15:8] <= byte_data;
            if (accept && state == DATA_LO) word[7:0]  <= byte_data;
            if (state == WRITE) addr <= addr_inc;
        end
    end

    // All outputs decode the state register or come straight from registers.
    always_comb begin
        byte_ready = 1'b0;
        unique case (state)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK: byte_ready = 1'b1;
            default:                               byte_ready = 1'b0;
        endcase
    end

    assign imem_we   = (state == WRITE);
    assign imem_addr = addr;
    assign imem_data = word;
    assign cpu_hold  = (state != DONE);
    assign done      = (state == DONE);
    assign error     = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader: stream vectors with
// hand-computed checksums, plus reset and timing sequences.
module tb_imem_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    imem_loader #(.DEPTH(1024), .ADDR_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Write monitor: records every write and its cycle.
    int          wr_cnt = 0;
    int          ready_in_write = 0;
    logic [15:0] wr_addr [8];
    logic [15:0] wr_data [8];
    int          wr_cyc  [8];
    int          acc_cyc [8];

    always @(negedge clock) begin
        if (imem_we) begin
            if (wr_cnt < 8) begin
                wr_addr[wr_cnt] = imem_addr;
                wr_data[wr_cnt] = imem_data;
                wr_cyc[wr_cnt]  = cyc;
            end
            wr_cnt = wr_cnt + 1;
            if (byte_ready) ready_in_write = ready_in_write + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_start(output int sc);
        @(negedge clock);
        start = 1'b1;
        sc = cyc;
        @(negedge clock);
        start = 1'b0;
        check("start_ready", {31'b0, byte_ready}, 32'd1);
    endtask

    // Called at a negedge; returns at the negedge after the last byte is accepted.
    task automatic send_stream(input logic [63:0] bytes, input int n, input logic stall,
                               input int start_at, output logic ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            int   tries;
            logic got;
            tries = 0;
            got   = 1'b0;
            byte_data = bytes[63-8*i -: 8];
            while (!got && tries < 200) begin
                byte_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                start = (i == start_at) && (tries == 0);
                if (byte_valid && byte_ready) begin
                    acc_cyc[i] = cyc;
                    got = 1'b1;
                end
                @(negedge clock);
                tries++;
            end
            start = 1'b0;
            if (!got) begin
                n_checks++;
                n_fails++;
                $display("FAIL stream_timeout: byte %0d not accepted, got ready=%0b, expected 1", i, byte_ready);
                ok = 1'b0;
                byte_valid = 1'b0;
                return;
            end
        end
        byte_valid = 1'b0;
    endtask

    typedef struct {
        logic [63:0] bytes;
        int          n;
        logic        stall;
        int          start_at;
        logic        exp_done;
        logic        exp_err;
        int          exp_wr;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int   sc;
        logic ok;

        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

        // Checksums: 00^02^12^34^AB^CD = 42 ; 00^01^BE^EF = 50.
        vecs[0] = '{64'h0002_1234_ABCD_4200, 7, 1'b0, -1, 1'b1, 1'b0, 2, 16'h1234, 16'hABCD};
        vecs[1] = '{64'h0002_1234_ABCD_4100, 7, 1'b0, -1, 1'b0, 1'b1, 2, 16'h1234, 16'hABCD};
        vecs[2] = '{64'h0401_0000_0000_0000, 2, 1'b0, -1, 1'b0, 1'b1, 0, 16'h0000, 16'h0000};
        vecs[3] = '{64'h0000_0000_0000_0000, 3, 1'b0, -1, 1'b1, 1'b0, 0, 16'h0000, 16'h0000};
        vecs[4] = '{64'h0001_BEEF_5000_0000, 5, 1'b0, -1, 1'b1, 1'b0, 1, 16'hBEEF, 16'h0000};
        vecs[5] = '{64'h0002_1234_ABCD_4200, 7, 1'b1,  3, 1'b1, 1'b0, 2, 16'h1234, 16'hABCD};

        repeat (3) @(negedge clock);
        check("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
        check("rst_imem_we",    {31'b0, imem_we},    32'd0);
        check("rst_imem_addr",  {16'b0, imem_addr},  32'd0);
        check("rst_imem_data",  {16'b0, imem_data},  32'd0);
        check("rst_cpu_hold",   {31'b0, cpu_hold},   32'd1);
        check("rst_done",       {31'b0, done},       32'd0);
        check("rst_error",      {31'b0, error},      32'd0);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) begin
            wr_cnt = 0;
            ready_in_write = 0;
            do_start(sc);
            send_stream(vecs[k].bytes, vecs[k].n, vecs[k].stall, vecs[k].start_at, ok);
            if (ok) begin
                check($sformatf("v%0d_done", k),     {31'b0, done},     {31'b0, vecs[k].exp_done});
                check($sformatf("v%0d_error", k),    {31'b0, error},    {31'b0, vecs[k].exp_err});
                check($sformatf("v%0d_cpu_hold", k), {31'b0, cpu_hold}, {31'b0, !vecs[k].exp_done});
                check($sformatf("v%0d_ready_after", k), {31'b0, byte_ready}, 32'd0);
                if (vecs[k].exp_done && !vecs[k].stall)
                    check($sformatf("v%0d_latency", k), cyc - sc, 4 + 3 * vecs[k].exp_wr);
            end
            repeat (2) @(negedge clock);
            check($sformatf("v%0d_wr_count", k), wr_cnt, vecs[k].exp_wr);
            check($sformatf("v%0d_ready_in_write", k), ready_in_write, 0);
            for (int w = 0; w < vecs[k].exp_wr && w < wr_cnt; w++) begin
                check($sformatf("v%0d_w%0d_addr", k, w), {16'b0, wr_addr[w]}, w);
                check($sformatf("v%0d_w%0d_data", k, w), {16'b0, wr_data[w]},
                      {16'b0, (w == 0) ? vecs[k].w0 : vecs[k].w1});
                check($sformatf("v%0d_w%0d_timing", k, w), wr_cyc[w], acc_cyc[3 + 2 * w] + 1);
            end
        end

        // Reset during the write cycle of the first word, then a clean reload.
        wr_cnt = 0;
        do_start(sc);
        send_stream(64'h0002_1234_0000_0000, 4, 1'b0, -1, ok);
        check("mid_we_before_reset", {31'b0, imem_we}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_imem_we",    {31'b0, imem_we},    32'd0);
        check("mid_rst_byte_ready", {31'b0, byte_ready}, 32'd0);
        check("mid_rst_cpu_hold",   {31'b0, cpu_hold},   32'd1);
        check("mid_rst_addr",       {16'b0, imem_addr},  32'd0);
        check("mid_rst_done",       {31'b0, done},       32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("mid_idle_ready", {31'b0, byte_ready}, 32'd0);
        wr_cnt = 0;
        do_start(sc);
        send_stream(64'h0002_1234_ABCD_4200, 7, 1'b0, -1, ok);
        check("reload_done",     {31'b0, done},     32'd1);
        check("reload_cpu_hold", {31'b0, cpu_hold}, 32'd0);
        check("reload_wr_count", wr_cnt, 2);
        if (wr_cnt >= 2) begin
            check("reload_w0_addr", {16'b0, wr_addr[0]}, 32'd0);
            check("reload_w0_data", {16'b0, wr_data[0]}, 32'h1234);
            check("reload_w1_addr", {16'b0, wr_addr[1]}, 32'd1);
            check("reload_w1_data", {16'b0, wr_data[1]}, 32'hABCD);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
